// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver.
//   - Line levels for start/stop bits.
//   - Oversampling ratio and first voted sample index.
//   - Sample-tick divisors (clocks per sample - 1) for each baud_set code.
//   - Receiver FSM state encoding.
package uart_pkg;

    localparam int OVS     = 16;
    localparam int VOTE_LO = 7;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int SDIV_W = 9;

    localparam logic [SDIV_W-1:0] SDIV_TEST   = 9'd1;    // 32 clk per bit
    localparam logic [SDIV_W-1:0] SDIV_19200  = 9'd162;
    localparam logic [SDIV_W-1:0] SDIV_38400  = 9'd80;
    localparam logic [SDIV_W-1:0] SDIV_57600  = 9'd53;
    localparam logic [SDIV_W-1:0] SDIV_115200 = 9'd26;
    localparam logic [SDIV_W-1:0] SDIV_9600   = 9'd325;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic logic [SDIV_W-1:0] baud_sdiv(input logic [3:0] sel);
        logic [SDIV_W-1:0] sdiv;
        case (sel)
            4'd0:    sdiv = SDIV_TEST;
            4'd1:    sdiv = SDIV_19200;
            4'd2:    sdiv = SDIV_38400;
            4'd3:    sdiv = SDIV_57600;
            4'd4:    sdiv = SDIV_115200;
            default: sdiv = SDIV_9600;
        endcase
        return sdiv;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator for the UART receiver.
// Holds a registered divisor looked up from baud_set and a counter that
// produces one tick every (divisor + 1) clocks while a frame is running.
// Ports:
//   mclk     in  system clock
//   rst_n    in  asynchronous active-low reset
//   run      in  frame in progress; counter idles at 0 otherwise
//   clr      in  start detected; restarts the count so sample 0 sits on the edge
//   baud_set in  baud select; only followed while run is low
//   tick     out one-clock sample strobe
module uart_rx_tick (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic [3:0] baud_set,
    output logic       tick
);
    import uart_pkg::*;

    logic [SDIV_W-1:0] sdiv_q, sdiv_d;
    logic [SDIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sdiv_d = sdiv_q;
        cnt_d  = '0;
        tick   = 1'b0;
        // The divisor is frozen for the whole frame; the value present on the
        // start-detect cycle is the one used.
        if (!run) begin
            sdiv_d = baud_sdiv(baud_set);
        end
        if (run && !clr) begin
            tick  = (cnt_q == sdiv_q);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sdiv_q <= SDIV_9600;
            cnt_q  <= '0;
        end else begin
            sdiv_q <= sdiv_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with 16x oversampling and 3-sample majority vote.
// Rejects start pulses that are not low at mid-bit, flags a low stop bit
// as a framing error and then waits for the line to go high again.
// Ports:
//   mclk       in  system clock
//   rst_n      in  asynchronous active-low reset
//   baud_set   in  baud select, captured at start of each frame
//   rs232_rx   in  asynchronous serial line (idle high)
//   data_byte  out last good byte, held until the next good frame
//   rx_done    out one-clock pulse, data_byte valid in the same cycle
//   frame_err  out one-clock pulse when the stop bit votes low
//   uart_state out high from start detect until the frame is finished
module uart_byte_rx #(
    parameter int OVS     = 16,
    parameter int VOTE_LO = 7
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [3:0] baud_set,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);
    import uart_pkg::*;

    localparam logic [3:0] SMP_V0   = 4'(VOTE_LO);
    localparam logic [3:0] SMP_V1   = 4'(VOTE_LO + 1);
    localparam logic [3:0] SMP_V2   = 4'(VOTE_LO + 2);
    localparam logic [3:0] SMP_LAST = 4'(OVS - 1);

    // [0] metastability stage, [1] synchronized line, [2] previous rx_s
    logic [2:0] rx_pipe_q, rx_pipe_d;
    logic       rx_s, rx_prev;

    rx_state_e  state_q, state_d;
    logic [3:0] smp_q, smp_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] vote_q, vote_d;
    logic [7:0] data_byte_q, data_byte_d;
    logic       rx_done_q, rx_done_d;
    logic       frame_err_q, frame_err_d;

    logic       tick;
    logic       start_det;
    logic       vote_maj;

    assign rx_pipe_d = {rx_pipe_q[1:0], rs232_rx};
    assign rx_s      = rx_pipe_q[1];
    assign rx_prev   = rx_pipe_q[2];

    assign uart_state = (state_q != ST_IDLE);
    assign start_det  = (state_q == ST_IDLE) && (rx_prev == STOP_BIT) && (rx_s == START_BIT);

    // Samples 7 and 8 are held in vote_q; sample 9 is the live rx_s.
    assign vote_maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    uart_rx_tick u_tick (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .run      (uart_state),
        .clr      (start_det),
        .baud_set (baud_set),
        .tick     (tick)
    );

    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        vote_d      = vote_q;
        data_byte_d = data_byte_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            smp_d = smp_q + 4'd1;
            if (smp_q == SMP_V0) vote_d[0] = rx_s;
            if (smp_q == SMP_V1) vote_d[1] = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d = ST_START;
                    smp_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (smp_q == SMP_V2 && vote_maj != START_BIT) begin
                        state_d = ST_IDLE;
                    end else if (smp_q == SMP_LAST) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (smp_q == SMP_V2) begin
                        shift_d[bit_q] = vote_maj;
                    end
                    if (smp_q == SMP_LAST) begin
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit lets a following start edge be
                // caught with no idle time between frames.
                if (tick && smp_q == SMP_V2) begin
                    if (vote_maj == STOP_BIT) begin
                        data_byte_d = shift_q;
                        rx_done_d   = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Only a return to high re-arms start detection, so a held-low
                // line yields one error rather than a stream of them.
                if (rx_s == STOP_BIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pipe_q   <= '1;
            state_q     <= ST_IDLE;
            smp_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            vote_q      <= '0;
            data_byte_q <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_pipe_q   <= rx_pipe_d;
            state_q     <= state_d;
            smp_q       <= smp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            vote_q      <= vote_d;
            data_byte_q <= data_byte_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data_byte = data_byte_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: drives 8N1 frames on the serial line and keeps a
// frame-level expectation queue (byte or framing error, plus the nominal
// cycle of the result pulse) checked every clock by one compare process.
module tb_uart_byte_rx;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] baud_set = 4'd0;
    logic       rs232_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    uart_byte_rx dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .baud_set   (baud_set),
        .rs232_rx   (rs232_rx),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always #5 mclk = ~mclk;

    int unsigned cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int unsigned last_done_cyc = 0;
    logic [7:0] held = 8'h00;

    typedef struct {
        bit          is_err;
        logic [7:0]  b;
        int unsigned due;
    } exp_t;
    exp_t expq[$];

    // Nominal clocks per oversample for each baud_set code.
    function automatic int clk_per_sample(input logic [3:0] s);
        case (s)
            4'd0:    return 2;
            4'd1:    return 163;
            4'd2:    return 81;
            4'd3:    return 54;
            4'd4:    return 27;
            default: return 326;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_window(input string name, input int unsigned due);
        vectors++;
        if (cyc + 2 < due || cyc > due + 2) begin
            miscompares++;
            $display("FAIL %s: pulse at cycle %0d expected %0d +/-2", name, cyc, due);
        end
    endtask

    // Compare process: every clock, on the falling edge.
    always @(negedge mclk) begin
        if (!rst_n) begin
            expq.delete();
            held = 8'h00;
            check("rst_data_byte", {24'd0, data_byte}, 32'h0);
            check("rst_rx_done", {31'd0, rx_done}, 32'h0);
            check("rst_frame_err", {31'd0, frame_err}, 32'h0);
            check("rst_uart_state", {31'd0, uart_state}, 32'h0);
        end else begin
            if (rx_done && frame_err) check("done_err_overlap", {31'd0, frame_err}, 32'h0);
            if (rx_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (expq.size() == 0 || expq[0].is_err) begin
                    check("unexpected_rx_done", {31'd0, rx_done}, 32'h0);
                end else begin
                    check_window("rx_done_time", expq[0].due);
                    check("rx_data", {24'd0, data_byte}, {24'd0, expq[0].b});
                    held = expq[0].b;
                    void'(expq.pop_front());
                end
            end
            if (frame_err) begin
                err_cnt++;
                if (expq.size() == 0 || !expq[0].is_err) begin
                    check("unexpected_frame_err", {31'd0, frame_err}, 32'h0);
                end else begin
                    check_window("frame_err_time", expq[0].due);
                    void'(expq.pop_front());
                end
            end
            if (expq.size() > 0 && cyc > expq[0].due + 2) begin
                if (expq[0].is_err) check("missing_frame_err", {31'd0, frame_err}, 32'h1);
                else                check("missing_rx_done", {31'd0, rx_done}, 32'h1);
                void'(expq.pop_front());
            end
            check("data_byte_hold", {24'd0, data_byte}, {24'd0, held});
        end
    end

    task automatic line_for(input logic lvl, input int n);
        rs232_rx = lvl;
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // Result of a frame is expected 9 5/8 bit periods (154 samples) after
    // the falling edge plus 3 clocks of input and output register latency.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bl);
        exp_t e;
        e.is_err = !stop;
        e.b      = b;
        e.due    = cyc + 154 * clk_per_sample(baud_set) + 3;
        expq.push_back(e);
        line_for(1'b0, bl);
        for (int i = 0; i < 8; i++) line_for(b[i], bl);
        line_for(stop, bl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int d0, e0;
    int unsigned t0;

    initial begin
        repeat (4) @(posedge mclk);
        #1;
        rst_n = 1'b1;
        line_for(1'b1, 40);

        // 1: single 0x55 at 32 clk/bit; baud_set moved mid-frame is ignored
        d0 = done_cnt; e0 = err_cnt; t0 = cyc;
        fork
            send_frame(8'h55, 1'b1, 32);
            begin
                repeat (100) @(posedge mclk);
                #2 baud_set = 4'd3;
            end
        join
        baud_set = 4'd0;
        line_for(1'b1, 64);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_err_count", err_cnt - e0, 0);
        check("t1_data", {24'd0, data_byte}, 32'h55);
        check("t1_state", {31'd0, uart_state}, 32'h0);
        check("t1_latency_near_312", (last_done_cyc - t0 >= 309 && last_done_cyc - t0 <= 314) ? 1 : 0, 1);

        // 2: back-to-back 0xA3, 0x00
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1, 32);
        send_frame(8'h00, 1'b1, 32);
        line_for(1'b1, 64);
        check("t2_done_count", done_cnt - d0, 2);
        check("t2_data", {24'd0, data_byte}, 32'h00);

        // 3: 10-clk glitch on idle line
        d0 = done_cnt; e0 = err_cnt;
        line_for(1'b0, 10);
        line_for(1'b1, 22);
        check("t3_idle_within_bit", {31'd0, uart_state}, 32'h0);
        line_for(1'b1, 300);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_no_err", err_cnt - e0, 0);

        // 4: good 0x12, then 0x0F with stop=0, then line high
        send_frame(8'h12, 1'b1, 32);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h0F, 1'b0, 32);
        check("t4_break_busy", {31'd0, uart_state}, 32'h1);
        line_for(1'b1, 64);
        check("t4_err_count", err_cnt - e0, 1);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_data_kept", {24'd0, data_byte}, 32'h12);
        check("t4_state", {31'd0, uart_state}, 32'h0);

        // 5: reset during bit 4 of 0x99, then 0xC7
        d0 = done_cnt;
        line_for(1'b0, 32);
        line_for(1'b1, 32);
        line_for(1'b0, 32);
        line_for(1'b0, 32);
        line_for(1'b1, 32);
        line_for(1'b1, 16);
        check("t5_busy_before_rst", {31'd0, uart_state}, 32'h1);
        rst_n = 1'b0;
        rs232_rx = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("t5_rst_data", {24'd0, data_byte}, 32'h0);
        check("t5_rst_state", {31'd0, uart_state}, 32'h0);
        rst_n = 1'b1;
        line_for(1'b1, 64);
        send_frame(8'hC7, 1'b1, 32);
        line_for(1'b1, 64);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_data", {24'd0, data_byte}, 32'hC7);

        // 6: 115200 setting, nominal and 2% slow bit time
        baud_set = 4'd4;
        line_for(1'b1, 10);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b1, 432);
        line_for(1'b1, 500);
        check("t6_data_432", {24'd0, data_byte}, 32'h3C);
        send_frame(8'h3C, 1'b1, 441);
        line_for(1'b1, 500);
        check("t6_done_count", done_cnt - d0, 2);
        check("t6_no_err", err_cnt - e0, 0);
        check("t6_data_441", {24'd0, data_byte}, 32'h3C);
        check("t6_state", {31'd0, uart_state}, 32'h0);

        check("expect_queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
